ddp_inject_arbiter: RTL and testbench

Clocked round-robin arbiter that shares the single external packet input of the JOIN dataflow pipeline among N_SRC packet sources. It wins one source, captures its 38-bit packet, and runs a four-phase Send/Ack handshake into the pipeline's external Send_in/PACKET_IN port. It completes the source-side four-phase handshake only after the pipeline has acknowledged. The pipeline-side Ack is asynchronous, so it is synchronized locally; a watchdog flags stalled transfers.

---
 rtl/ddp_inject_arbiter_if.sv | 37 +++
 rtl/ddp_inject_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ddp_inject_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddp_inject_arbiter_if.sv
// ----------------------------------------------------------------------------
// ddp_inject_arbiter_if
//   Bundles the source-side request/packet/ack lines, the pipeline-side
//   Send/Ack/packet lines and the status/error lines of ddp_inject_arbiter.
//
//   slave  : the arbiter's view (sources and pipeline ack in; ack, send,
//            packet, grant and status out)
//   master : the environment's view (sources, pipeline ack and error clear
//            driven; everything the arbiter produces observed)
// ----------------------------------------------------------------------------
interface ddp_inject_arbiter_if #(
   parameter int N_SRC = 4,
   parameter int PKT_W = 38
);
   localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   logic [N_SRC-1:0]       SRC_SEND;
   logic [N_SRC*PKT_W-1:0] SRC_PACKET;
   logic [N_SRC-1:0]       SRC_ACK;
   logic                   DDP_SEND;
   logic [PKT_W-1:0]       DDP_PACKET;
   logic                   DDP_ACK;
   logic [ID_W-1:0]        GRANT_ID;
   logic                   BUSY;
   logic                   TIMEOUT_ERR;
   logic                   ERR_CLR;

   modport slave (
      input  SRC_SEND, SRC_PACKET, DDP_ACK, ERR_CLR,
      output SRC_ACK, DDP_SEND, DDP_PACKET, GRANT_ID, BUSY, TIMEOUT_ERR
   );

   modport master (
      output SRC_SEND, SRC_PACKET, DDP_ACK, ERR_CLR,
      input  SRC_ACK, DDP_SEND, DDP_PACKET, GRANT_ID, BUSY, TIMEOUT_ERR
   );
endinterface

// File: rtl/ddp_inject_arbiter.sv
// ----------------------------------------------------------------------------
// ddp_inject_arbiter
//   Round-robin arbiter sharing the single external packet input of the JOIN
//   dataflow pipeline among N_SRC sources. A winning source's packet is
//   captured and offered to the pipeline with a four-phase Send/Ack
//   handshake; the source is acknowledged (four-phase) only once the
//   pipeline has completed its return-to-zero. The pipeline Ack is
//   asynchronous and passes through a SYNC_STAGES-deep synchronizer. A
//   watchdog raises a sticky flag when a transfer stalls.
//
//   Ports
//     CP    : clock, all state on the rising edge
//     MR_N  : asynchronous active-low master reset
//     bus   : ddp_inject_arbiter_if.slave
//             SRC_SEND/SRC_PACKET/SRC_ACK  source handshakes and packets
//             DDP_SEND/DDP_PACKET/DDP_ACK  pipeline handshake and packet
//             GRANT_ID                     current or last granted source
//             BUSY                         high whenever not IDLE
//             TIMEOUT_ERR/ERR_CLR          sticky watchdog flag and clear
// ----------------------------------------------------------------------------
module ddp_inject_arbiter #(
   parameter int N_SRC       = 4,
   parameter int PKT_W       = 38,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic                 CP,
   input  logic                 MR_N,
   ddp_inject_arbiter_if.slave  bus
);
   localparam int IDW  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SEND, RTZ, SACK} state_t;

   state_t                 state_q, state_d;
   logic [N_SRC-1:0]       src_ack_q, src_ack_d;
   logic                   ddp_send_q, ddp_send_d;
   logic [PKT_W-1:0]       pkt_q, pkt_d;
   logic [IDW-1:0]         grant_q, grant_d;
   logic [IDW-1:0]         rr_q, rr_d;
   logic                   busy_q, busy_d;
   logic                   err_q, err_d;
   logic [WD_W-1:0]        wd_q, wd_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;

   logic                   ack_s;
   logic                   win_found;
   logic [IDW-1:0]         win_idx;
   logic [IDW-1:0]         cand_idx;
   logic [PKT_W-1:0]       src_pkt [N_SRC];

   // Ack synchronizer; only the last stage is ever looked at.
   assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.DDP_ACK};
   assign ack_s  = sync_q[SYNC_STAGES-1];

   always_comb begin
      for (int i = 0; i < N_SRC; i++) begin
         src_pkt[i] = bus.SRC_PACKET[i*PKT_W +: PKT_W];
      end
   end

   // First requester at or above the RR pointer, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_idx  = '0;
      for (int k = 0; k < N_SRC; k++) begin
         cand_idx = IDW'((int'(rr_q) + k) % N_SRC);
         if (!win_found && bus.SRC_SEND[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      src_ack_d  = src_ack_q;
      ddp_send_d = ddp_send_q;
      pkt_d      = pkt_q;
      grant_d    = grant_q;
      rr_d       = rr_q;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d    = win_idx;
               pkt_d      = src_pkt[win_idx];
               ddp_send_d = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            ddp_send_d = 1'b1;
            if (ack_s) begin
               ddp_send_d = 1'b0;
               state_d    = RTZ;
            end
         end
         RTZ: begin
            if (!ack_s) begin
               src_ack_d          = '0;
               src_ack_d[grant_q] = 1'b1;
               state_d            = SACK;
            end
         end
         SACK: begin
            // A source that already dropped its request gets a single-cycle ack.
            if (!bus.SRC_SEND[grant_q]) begin
               src_ack_d = '0;
               rr_d      = (grant_q == IDW'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_d = (state_d != IDLE);

   // Watchdog: counts SEND/RTZ cycles, saturates at TIMEOUT. The flag is set
   // only on the cycle the limit is reached, so a clear while still stalled
   // sticks; a set on the same edge as a clear wins.
   always_comb begin
      wd_d  = wd_q;
      err_d = err_q;
      if (state_d == IDLE) begin
         wd_d = '0;
      end else if ((state_q == SEND || state_q == RTZ) && wd_q != WD_MAX) begin
         wd_d = wd_q + 1'b1;
      end
      if (bus.ERR_CLR) begin
         err_d = 1'b0;
      end
      if (TIMEOUT > 0 && wd_q != WD_MAX && wd_d == WD_MAX) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge CP or negedge MR_N) begin
      if (!MR_N) begin
         state_q    <= IDLE;
         src_ack_q  <= '0;
         ddp_send_q <= 1'b0;
         pkt_q      <= '0;
         grant_q    <= '0;
         rr_q       <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         wd_q       <= '0;
         sync_q     <= '0;
      end else begin
         state_q    <= state_d;
         src_ack_q  <= src_ack_d;
         ddp_send_q <= ddp_send_d;
         pkt_q      <= pkt_d;
         grant_q    <= grant_d;
         rr_q       <= rr_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         wd_q       <= wd_d;
         sync_q     <= sync_d;
      end
   end

   assign bus.SRC_ACK     = src_ack_q;
   assign bus.DDP_SEND    = ddp_send_q;
   assign bus.DDP_PACKET  = pkt_q;
   assign bus.GRANT_ID    = grant_q;
   assign bus.BUSY        = busy_q;
   assign bus.TIMEOUT_ERR = err_q;
endmodule

// File: tb/tb_ddp_inject_arbiter.sv
module tb_ddp_inject_arbiter;
   localparam int N   = 4;
   localparam int PW  = 38;
   localparam int TMO = 10;

   logic CP   = 1'b0;
   logic MR_N = 1'b0;

   ddp_inject_arbiter_if #(.N_SRC(N), .PKT_W(PW)) bus ();

   ddp_inject_arbiter #(
      .N_SRC(N), .PKT_W(PW), .SYNC_STAGES(2), .TIMEOUT(TMO)
   ) dut (
      .CP(CP), .MR_N(MR_N), .bus(bus)
   );

   always #5 CP = ~CP;

   int n_chk  = 0;
   int n_fail = 0;
   int resp_en  = 1;
   int resp_dly = 0;
   int rtz_dly  = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge CP);
   endtask

   task automatic set_pkt(input int i, input logic [PW-1:0] v);
      bus.SRC_PACKET[i*PW +: PW] = v;
   endtask

   task automatic do_reset();
      step();
      MR_N           = 1'b0;
      bus.SRC_SEND   = '0;
      bus.SRC_PACKET = '0;
      bus.ERR_CLR    = 1'b0;
      bus.DDP_ACK    = 1'b0;
      resp_en        = 1;
      step();
      step();
      MR_N = 1'b1;
   endtask

   // Wait for a transfer to start, then for its source ack; drop the acked
   // request and move one cycle on (arbiter back in IDLE).
   task automatic serve(output int gid, output logic [PW-1:0] pkt, output int wcyc);
      int c;
      gid  = -1;
      pkt  = '0;
      wcyc = 0;
      while (!bus.DDP_SEND && wcyc < 40) begin
         step();
         wcyc++;
      end
      check_val("serve_send", bus.DDP_SEND, 1);
      gid = int'(bus.GRANT_ID);
      pkt = bus.DDP_PACKET;
      c = 0;
      while (bus.SRC_ACK == '0 && c < 40) begin
         step();
         c++;
      end
      check_val("serve_ack", bus.SRC_ACK != '0, 1);
      bus.SRC_SEND = bus.SRC_SEND & ~bus.SRC_ACK;
      step();
   endtask

   // Reference arbitration rule: scan source indices starting at the pointer.
   function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
      int order[$];
      for (int k = 0; k < N; k++) order.push_back((ptr + k) % N);
      foreach (order[k]) if (req[order[k]]) return order[k];
      return -1;
   endfunction

   // Pipeline model: raise Ack resp_dly cycles after Send, drop it rtz_dly
   // cycles after Send falls.
   initial begin
      int rcnt;
      rcnt = 0;
      forever begin
         @(negedge CP);
         if (resp_en != 0) begin
            if (bus.DDP_SEND && !bus.DDP_ACK) begin
               if (rcnt >= resp_dly) begin
                  bus.DDP_ACK = 1'b1;
                  rcnt = 0;
               end else rcnt++;
            end else if (!bus.DDP_SEND && bus.DDP_ACK) begin
               if (rcnt >= rtz_dly) begin
                  bus.DDP_ACK = 1'b0;
                  rcnt = 0;
               end else rcnt++;
            end else rcnt = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge CP);
         if (MR_N) check_val("ack_onehot", $onehot0(bus.SRC_ACK), 1);
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   int gid, wcyc, lat, c, eg, go, cur, just, rr_m, nx;
   logic prev_send;
   logic [PW-1:0] pkt;
   logic [PW-1:0] pk [N];
   int waits [N];
   logic [63:0] r64;

   initial begin
      bus.SRC_SEND   = '0;
      bus.SRC_PACKET = '0;
      bus.ERR_CLR    = 1'b0;
      bus.DDP_ACK    = 1'b0;

      // Reset state
      step();
      check_val("rst_src_ack", bus.SRC_ACK, 0);
      check_val("rst_send", bus.DDP_SEND, 0);
      check_val("rst_pkt", bus.DDP_PACKET, 0);
      check_val("rst_gid", bus.GRANT_ID, 0);
      check_val("rst_busy", bus.BUSY, 0);
      check_val("rst_err", bus.TIMEOUT_ERR, 0);
      MR_N = 1'b1;
      step();

      // Single source 2, pipeline acks 3 cycles after Send
      resp_dly = 3;
      rtz_dly  = 0;
      set_pkt(2, 38'h2A_BCDE_F012);
      bus.SRC_SEND = 4'b0100;
      step();
      check_val("t1_send", bus.DDP_SEND, 1);
      check_val("t1_pkt", bus.DDP_PACKET, 38'h2A_BCDE_F012);
      check_val("t1_gid", bus.GRANT_ID, 2);
      check_val("t1_busy", bus.BUSY, 1);
      lat = 0;
      while (bus.SRC_ACK == '0 && lat < 40) begin
         step();
         lat++;
      end
      check_val("t1_ack_lat", lat, 9);
      check_val("t1_ack", bus.SRC_ACK, 4'b0100);
      check_val("t1_ddp_ack_low", bus.DDP_ACK, 0);
      bus.SRC_SEND = '0;
      step();
      check_val("t1_ack_clr", bus.SRC_ACK, 0);
      check_val("t1_idle", bus.BUSY, 0);
      check_val("t1_err", bus.TIMEOUT_ERR, 0);

      // Sources 0 and 3 together from reset
      do_reset();
      resp_dly = 1;
      set_pkt(0, 38'h01_2345_6789);
      set_pkt(3, 38'h3F_FEDC_BA98);
      bus.SRC_SEND = 4'b1001;
      serve(gid, pkt, wcyc);
      check_val("t2_gid0", gid, 0);
      check_val("t2_pkt0", pkt, 38'h01_2345_6789);
      serve(gid, pkt, wcyc);
      check_val("t2_gid1", gid, 3);
      check_val("t2_pkt1", pkt, 38'h3F_FEDC_BA98);
      check_val("t2_nowait", wcyc, 1);
      bus.SRC_SEND = 4'b1001;
      serve(gid, pkt, wcyc);
      check_val("t2_ptr_wrap", gid, 0);
      serve(gid, pkt, wcyc);

      // All four continuously requesting
      do_reset();
      for (int i = 0; i < N; i++) begin
         pk[i] = PW'(38'h10_0000_0000 + i * 38'h11_1111);
         set_pkt(i, pk[i]);
      end
      bus.SRC_SEND = 4'b1111;
      for (int t = 0; t < 8; t++) begin
         serve(gid, pkt, wcyc);
         check_val("t3_order", gid, t % N);
         check_val("t3_pkt", pkt, pk[t % N]);
         check_val("t3_gap", wcyc, 1);
         bus.SRC_SEND = 4'b1111;
      end
      bus.SRC_SEND = '0;
      step();
      step();

      // Watchdog with the pipeline silent
      do_reset();
      resp_en     = 0;
      bus.DDP_ACK = 1'b0;
      set_pkt(0, 38'h15_5555_5555);
      bus.SRC_SEND = 4'b0001;
      step();
      check_val("t4_send", bus.DDP_SEND, 1);
      for (int k = 0; k < 9; k++) step();
      check_val("t4_err_early", bus.TIMEOUT_ERR, 0);
      bus.ERR_CLR = 1'b1;
      step();
      bus.ERR_CLR = 1'b0;
      check_val("t4_set_wins", bus.TIMEOUT_ERR, 1);
      for (int k = 0; k < 5; k++) step();
      check_val("t4_sticky", bus.TIMEOUT_ERR, 1);
      bus.ERR_CLR = 1'b1;
      step();
      bus.ERR_CLR = 1'b0;
      check_val("t4_clr", bus.TIMEOUT_ERR, 0);
      for (int k = 0; k < 3; k++) step();
      check_val("t4_stays_clr", bus.TIMEOUT_ERR, 0);
      check_val("t4_still_send", bus.DDP_SEND, 1);
      resp_dly = 0;
      rtz_dly  = 0;
      resp_en  = 1;
      c = 0;
      while (bus.SRC_ACK == '0 && c < 40) begin
         step();
         c++;
      end
      check_val("t4_late_ack", bus.SRC_ACK, 4'b0001);
      check_val("t4_late_pkt", bus.DDP_PACKET, 38'h15_5555_5555);
      bus.SRC_SEND = '0;
      step();
      check_val("t4_idle", bus.BUSY, 0);

      // Reset while in RTZ
      do_reset();
      resp_dly = 0;
      rtz_dly  = 1;
      set_pkt(2, 38'h22_2222_2222);
      bus.SRC_SEND = 4'b0100;
      serve(gid, pkt, wcyc);
      check_val("t5_first", gid, 2);
      set_pkt(2, 38'h2E_EEEE_EEEE);
      bus.SRC_SEND = 4'b0100;
      step();
      check_val("t5_send", bus.DDP_SEND, 1);
      c = 0;
      while (bus.DDP_SEND && c < 20) begin
         step();
         c++;
      end
      check_val("t5_in_rtz", {bus.DDP_SEND, bus.BUSY}, 2'b01);
      #1 MR_N = 1'b0;
      #1;
      check_val("t5_async_ack", bus.SRC_ACK, 0);
      check_val("t5_async_send", bus.DDP_SEND, 0);
      check_val("t5_async_pkt", bus.DDP_PACKET, 0);
      check_val("t5_async_gid", bus.GRANT_ID, 0);
      check_val("t5_async_busy", bus.BUSY, 0);
      set_pkt(3, 38'h33_3333_3333);
      bus.SRC_SEND = 4'b1100;
      step();
      step();
      step();
      MR_N = 1'b1;
      step();
      check_val("t5_restart_send", bus.DDP_SEND, 1);
      check_val("t5_restart_gid", bus.GRANT_ID, 2);
      check_val("t5_restart_pkt", bus.DDP_PACKET, 38'h2E_EEEE_EEEE);
      serve(gid, pkt, wcyc);
      serve(gid, pkt, wcyc);
      check_val("t5_then3", gid, 3);

      // Source 1 drops its request during SEND
      do_reset();
      resp_dly = 2;
      rtz_dly  = 0;
      set_pkt(1, 38'h0A_5A5A_5A5A);
      bus.SRC_SEND = 4'b0010;
      step();
      check_val("t6_send", bus.DDP_SEND, 1);
      check_val("t6_gid", bus.GRANT_ID, 1);
      bus.SRC_SEND = '0;
      set_pkt(1, 38'h35_A5A5_A5A5);
      c = 0;
      while (bus.SRC_ACK == '0 && c < 40) begin
         step();
         c++;
      end
      check_val("t6_ack", bus.SRC_ACK, 4'b0010);
      check_val("t6_pkt", bus.DDP_PACKET, 38'h0A_5A5A_5A5A);
      step();
      check_val("t6_pulse", bus.SRC_ACK, 0);
      check_val("t6_idle", bus.BUSY, 0);

      // Random traffic against the reference arbitration rule
      do_reset();
      rr_m = 0;
      prev_send = 1'b0;
      nx = 0;
      cur = 0;
      for (int i = 0; i < N; i++) begin
         waits[i] = 0;
         pk[i] = '0;
      end
      for (int cyc = 0; cyc < 2000; cyc++) begin
         step();
         just = -1;
         if (bus.DDP_SEND && !prev_send) begin
            eg = rr_pick(bus.SRC_SEND, rr_m);
            check_val("rnd_req_seen", eg >= 0, 1);
            check_val("rnd_gid", bus.GRANT_ID, eg);
            if (eg >= 0) check_val("rnd_pkt", bus.DDP_PACKET, pk[eg]);
            go = int'(bus.GRANT_ID);
            check_val("rnd_fair", waits[go] <= N - 1, 1);
            for (int i = 0; i < N; i++) if (bus.SRC_SEND[i] && i != go) waits[i]++;
            waits[go] = 0;
            cur = (eg >= 0) ? eg : go;
         end
         if (bus.SRC_ACK != '0) begin
            check_val("rnd_ack", bus.SRC_ACK, 64'(1) << cur);
            check_val("rnd_err", bus.TIMEOUT_ERR, 0);
            bus.SRC_SEND[cur] = 1'b0;
            rr_m = (cur + 1) % N;
            nx++;
            resp_dly = $urandom_range(0, 2);
            rtz_dly  = $urandom_range(0, 1);
            just = cur;
         end
         for (int i = 0; i < N; i++) begin
            if (!bus.SRC_SEND[i] && i != just && $urandom_range(0, 3) == 0) begin
               r64 = {$urandom(), $urandom()};
               pk[i] = r64[PW-1:0];
               set_pkt(i, pk[i]);
               bus.SRC_SEND[i] = 1'b1;
            end
         end
         prev_send = bus.DDP_SEND;
      end
      check_val("rnd_progress", nx >= 50, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
